spi_responder: RTL and testbench

Synchronous SPI target (mode 0) that answers the Oberon SPI master, i.e. the other end of the SD-card/network SPI link. It oversamples SCLK/MOSI/nSS in its own clock domain, shifts out a host-loaded transmit word on MISO, and delivers each received byte or word to the host with a ready/ack handshake. It is used as the network-side endpoint on the shared SPI bus; its MISO idles high so it can be ANDed with other MISO sources.

---
 rtl/spi_responder_pkg.sv | 19 +
 rtl/spi_edge_sync.sv | 33 +++
 rtl/spi_responder.sv | 206 ++++++++++++++++++++
 tb/tb_spi_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_responder_pkg.sv
// Shared constants and helpers for the SPI responder: bit-index type,
// frame-length limits and the wire-order to data-bit mapping.
package spi_responder_pkg;

   localparam int IDX_W = 5;

   typedef logic [IDX_W-1:0] bit_idx_t;

   // Index of the final wire bit in a narrow (8-bit) and a wide (32-bit) frame
   localparam bit_idx_t LAST_NARROW = 5'd7;
   localparam bit_idx_t LAST_WIDE   = 5'd31;

   // Bytes travel least-significant first, bits inside a byte MSB first:
   // wire bit k carries data bit 8*(k/8) + 7 - (k%8).
   function automatic bit_idx_t wire_to_data(input bit_idx_t k);
      return {k[4:3], ~k[2:0]};
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchroniser for one asynchronous input, with single-cycle
// rise/fall pulses derived from the last two synchronised samples.
module spi_edge_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Shift the raw input through the synchroniser and keep one older sample
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 target: oversamples SCLK/MOSI/nSS, shifts a host-loaded word
// out on MISO and hands each received byte/word to the host with rxrdy/rxack.
// MISO idles high so it can be ANDed with other MISO sources on the bus.
module spi_responder
   import spi_responder_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] IDLE_WORD   = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SCLK,
   input  logic        MOSI,
   input  logic        nSS,
   output logic        MISO,
   input  logic        wide,
   input  logic [31:0] txdata,
   input  logic        txwr,
   output logic        txempty,
   output logic [31:0] rxdata,
   output logic        rxrdy,
   input  logic        rxack,
   output logic        ovr,
   output logic        udr,
   input  logic        clr,
   output logic        busy
);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;
   logic ss_lvl, ss_rise, ss_fall;
   logic unused_mosi_edges;

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .async_i(SCLK),
      .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .async_i(MOSI),
      .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nss (
      .clk(clk), .rst(rst), .async_i(nSS),
      .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall));

   // MOSI is only sampled as a level; SCLK level is only needed for edges
   assign unused_mosi_edges = mosi_rise ^ mosi_fall ^ sclk_lvl;

   logic        wide_q, wide_d;
   bit_idx_t    cnt_q, cnt_d;
   logic [31:0] tx_shift_q, tx_shift_d;
   logic [31:0] rx_shift_q, rx_shift_d;
   logic [31:0] hold_q, hold_d;
   logic        txempty_q, txempty_d;
   logic [31:0] rxdata_q, rxdata_d;
   logic        rxrdy_q, rxrdy_d;
   logic        ovr_q, ovr_d;
   logic        udr_q, udr_d;
   logic        miso_q, miso_d;
   logic        busy_q, busy_d;
   logic        load_pend_q, load_pend_d;
   logic        load_done_q, load_done_d;

   logic        sel_low, complete, load, ovr_set, udr_set;
   bit_idx_t    last_idx;
   logic [31:0] rx_word;

   // Next-state logic for counter, shifters, holding/RX registers and flags
   always_comb begin
      wide_d      = wide_q;
      cnt_d       = cnt_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      hold_d      = hold_q;
      txempty_d   = txempty_q;
      rxdata_d    = rxdata_q;
      rxrdy_d     = rxrdy_q;
      miso_d      = miso_q;
      load_pend_d = 1'b0;
      load_done_d = 1'b0;
      complete    = 1'b0;
      load        = 1'b0;
      ovr_set     = 1'b0;
      udr_set     = 1'b0;
      sel_low     = ~ss_lvl;
      busy_d      = ~ss_lvl;
      last_idx    = wide_q ? LAST_WIDE : LAST_NARROW;
      rx_word     = rx_shift_q;
      rx_word[wire_to_data(cnt_q)] = mosi_lvl;

      // Frame start: latch the frame width, restart the bit count, fetch a word
      if (ss_fall) begin
         wide_d = wide;
         cnt_d  = '0;
         load   = 1'b1;
      end

      // Next word of a multi-word frame is fetched the cycle after completion
      if (load_pend_q && sel_low) begin
         load = 1'b1;
      end

      if (sclk_rise && sel_low) begin
         rx_shift_d = rx_word;
         if (cnt_q == last_idx) begin
            cnt_d       = '0;
            complete    = 1'b1;
            load_pend_d = 1'b1;
         end else begin
            cnt_d = cnt_q + bit_idx_t'(1);
         end
      end

      // An empty holding register yields the idle word and flags an underrun
      if (load) begin
         load_done_d = 1'b1;
         txempty_d   = 1'b1;
         if (txempty_q) begin
            tx_shift_d = IDLE_WORD;
            udr_set    = 1'b1;
         end else begin
            tx_shift_d = hold_q;
         end
      end

      // A host write lands after any same-cycle load has used the old content
      if (txwr) begin
         hold_d    = txdata;
         txempty_d = 1'b0;
      end

      if (load_done_q) begin
         miso_d = tx_shift_q[wire_to_data(bit_idx_t'(0))];
      end
      if (sclk_fall && sel_low) begin
         miso_d = tx_shift_q[wire_to_data(cnt_q)];
      end

      // Deselect drops any partial word and releases MISO high
      if (ss_rise) begin
         cnt_d       = '0;
         miso_d      = 1'b1;
         load_pend_d = 1'b0;
      end

      if (complete) begin
         if (!rxrdy_q || rxack) begin
            rxdata_d = wide_q ? rx_word : {24'b0, rx_word[7:0]};
            rxrdy_d  = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (rxack) begin
         rxrdy_d = 1'b0;
      end

      ovr_d = clr ? 1'b0 : ovr_q;
      udr_d = clr ? 1'b0 : udr_q;
      if (ovr_set) ovr_d = 1'b1;
      if (udr_set) udr_d = 1'b1;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         wide_q      <= 1'b0;
         cnt_q       <= '0;
         tx_shift_q  <= IDLE_WORD;
         rx_shift_q  <= IDLE_WORD;
         hold_q      <= '0;
         txempty_q   <= 1'b1;
         rxdata_q    <= '0;
         rxrdy_q     <= 1'b0;
         ovr_q       <= 1'b0;
         udr_q       <= 1'b0;
         miso_q      <= 1'b1;
         busy_q      <= 1'b0;
         load_pend_q <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         wide_q      <= wide_d;
         cnt_q       <= cnt_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         hold_q      <= hold_d;
         txempty_q   <= txempty_d;
         rxdata_q    <= rxdata_d;
         rxrdy_q     <= rxrdy_d;
         ovr_q       <= ovr_d;
         udr_q       <= udr_d;
         miso_q      <= miso_d;
         busy_q      <= busy_d;
         load_pend_q <= load_pend_d;
         load_done_q <= load_done_d;
      end
   end

   assign MISO    = miso_q;
   assign txempty = txempty_q;
   assign rxdata  = rxdata_q;
   assign rxrdy   = rxrdy_q;
   assign ovr     = ovr_q;
   assign udr     = udr_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: bit-banged SPI master, host-side tasks and a
// transaction-level model of the holding register, RX register and flags.
module tb_spi_responder;

   localparam int          SYNC  = 2;
   localparam int          HALF  = 6;
   localparam int          SETUP = 6;
   localparam logic [31:0] IDLE  = 32'hFFFF_FFFF;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        SCLK = 1'b0, MOSI = 1'b0, nSS = 1'b1;
   logic        wide = 1'b0, txwr = 1'b0, rxack = 1'b0, clr = 1'b0;
   logic [31:0] txdata = '0;
   logic        MISO, txempty, rxrdy, ovr, udr, busy;
   logic [31:0] rxdata;

   always #5 clk = ~clk;

   spi_responder #(.SYNC_STAGES(SYNC), .IDLE_WORD(IDLE)) dut (
      .clk(clk), .rst(rst), .SCLK(SCLK), .MOSI(MOSI), .nSS(nSS), .MISO(MISO),
      .wide(wide), .txdata(txdata), .txwr(txwr), .txempty(txempty),
      .rxdata(rxdata), .rxrdy(rxrdy), .rxack(rxack), .ovr(ovr), .udr(udr),
      .clr(clr), .busy(busy));

   // ---------------- scoreboard / model ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] m_hold   = '0;
   logic [31:0] m_rxdata = '0;
   bit          m_empty = 1'b1, m_rxrdy = 1'b0, m_ovr = 1'b0, m_udr = 1'b0;
   bit          cur_wide = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // A word is fetched for the wire: the held word, or the idle word on underrun
   function automatic void m_load();
      if (m_empty) begin
         exp_q.push_back(IDLE);
         m_udr = 1'b1;
      end else begin
         exp_q.push_back(m_hold);
      end
      m_empty = 1'b1;
   endfunction

   // A received word is offered to the host
   function automatic void m_complete(input logic [31:0] w, input bit ack_now);
      logic [31:0] v;
      v = cur_wide ? w : (w & 32'h0000_00FF);
      if (!m_rxrdy || ack_now) begin
         m_rxdata = v;
         m_rxrdy  = 1'b1;
      end else begin
         m_ovr = 1'b1;
      end
   endfunction

   task automatic check_state(input string t);
      check({t, ".rxdata"},  rxdata,  m_rxdata);
      check({t, ".rxrdy"},   {31'b0, rxrdy},   {31'b0, m_rxrdy});
      check({t, ".ovr"},     {31'b0, ovr},     {31'b0, m_ovr});
      check({t, ".udr"},     {31'b0, udr},     {31'b0, m_udr});
      check({t, ".txempty"}, {31'b0, txempty}, {31'b0, m_empty});
   endtask

   // ---------------- host driver tasks ----------------
   task automatic host_write(input logic [31:0] d);
      @(negedge clk); txdata = d; txwr = 1'b1;
      @(negedge clk); txwr = 1'b0;
      m_hold = d; m_empty = 1'b0;
   endtask

   task automatic host_ack();
      @(negedge clk); rxack = 1'b1;
      @(negedge clk); rxack = 1'b0;
      m_rxrdy = 1'b0;
   endtask

   task automatic host_clr();
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      m_ovr = 1'b0; m_udr = 1'b0;
   endtask

   // ---------------- SPI master driver tasks ----------------
   // Optionally strobes txwr exactly on the cycle the responder fetches a word
   task automatic spi_select(input bit w, input bit wr_on_load, input logic [31:0] wd);
      @(negedge clk); wide = w; cur_wide = w; nSS = 1'b0;
      if (wr_on_load) begin
         repeat (2) @(negedge clk);
         txdata = wd; txwr = 1'b1;
         @(negedge clk); txwr = 1'b0;
         repeat (SETUP - 3) @(negedge clk);
      end else begin
         repeat (SETUP) @(negedge clk);
      end
      m_load();
      if (wr_on_load) begin
         m_hold = wd; m_empty = 1'b0;
      end
      check("busy_sel", {31'b0, busy}, 32'd1);
      wide = ~w;
   endtask

   // Shifts nbits of d (wire order) and reassembles what MISO returned;
   // ack_last raises rxack on the cycle the final bit is detected.
   task automatic spi_word(input logic [31:0] d, input int nbits, input bit ack_last, input string tag);
      logic [31:0] rd;
      logic [31:0] exp;
      int di;
      int full;
      rd   = '0;
      full = cur_wide ? 32 : 8;
      for (int k = 0; k < nbits; k++) begin
         di   = 8 * (k / 8) + 7 - (k % 8);
         MOSI = d[di];
         repeat (HALF) @(negedge clk);
         rd[di] = MISO;
         SCLK   = 1'b1;
         if (ack_last && k == nbits - 1) begin
            repeat (2) @(negedge clk);
            rxack = 1'b1;
            @(negedge clk); rxack = 1'b0;
            repeat (HALF - 3) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         SCLK = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      if (nbits == full) begin
         exp = exp_q.pop_front();
         check(tag, rd, cur_wide ? exp : (exp & 32'h0000_00FF));
         m_complete(d, ack_last);
         m_load();
      end
   endtask

   task automatic spi_deselect();
      @(negedge clk); nSS = 1'b1;
      repeat (SYNC + 4) @(negedge clk);
      void'(exp_q.pop_front());
      check("miso_idle", {31'b0, MISO}, 32'd1);
      check("busy_idle", {31'b0, busy}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      logic [31:0] b1;
      int nw;

      repeat (4) @(negedge clk);
      check("rst_miso", {31'b0, MISO}, 32'd1);
      check_state("rst");
      check("rst_busy", {31'b0, busy}, 32'd0);
      rst = 1'b1;

      // Idle with nSS high
      for (int i = 0; i < 5; i++) begin
         repeat (20) @(negedge clk);
         check("idle_miso", {31'b0, MISO}, 32'd1);
         check_state("idle");
      end

      // 8-bit frame
      host_write(32'h0000_00A5);
      spi_select(1'b0, 1'b0, '0);
      spi_word(32'h0000_003C, 8, 1'b0, "t8_miso");
      spi_deselect();
      check("t8_rxdata_const", rxdata, 32'h0000_003C);
      check_state("t8");
      host_ack();
      check("t8_ack", {31'b0, rxrdy}, 32'd0);

      // 32-bit back-to-back with a refill after the first fetch
      host_write(32'h1122_3344);
      spi_select(1'b1, 1'b0, '0);
      host_write(32'h5566_7788);
      spi_word(32'hDEAD_BEEF, 32, 1'b0, "t32_w0");
      check("t32_rx0", rxdata, 32'hDEAD_BEEF);
      host_ack();
      spi_word(32'h0BAD_F00D, 32, 1'b0, "t32_w1");
      check("t32_rx1", rxdata, 32'h0BAD_F00D);
      check("t32_ovr", {31'b0, ovr}, 32'd0);
      spi_deselect();
      check_state("t32");
      host_ack();

      // Overrun / underrun
      host_clr();
      b1 = $urandom;
      spi_select(1'b0, 1'b0, '0);
      spi_word(b1, 8, 1'b0, "ou_f0");
      spi_deselect();
      spi_select(1'b0, 1'b0, '0);
      spi_word($urandom, 8, 1'b0, "ou_f1");
      spi_deselect();
      check("ou_rxdata", rxdata, b1 & 32'h0000_00FF);
      check("ou_ovr", {31'b0, ovr}, 32'd1);
      check("ou_udr", {31'b0, udr}, 32'd1);
      check_state("ou");
      host_clr();
      check_state("ou_clr");
      host_ack();

      // Abort after 5 bits; the fetched word is gone
      host_write(32'hCAFE_BABE);
      spi_select(1'b1, 1'b0, '0);
      spi_word($urandom, 5, 1'b0, "ab_part");
      spi_deselect();
      check("ab_rxrdy", {31'b0, rxrdy}, 32'd0);
      spi_select(1'b1, 1'b0, '0);
      spi_word(32'h1234_5678, 32, 1'b0, "ab_next");
      spi_deselect();
      check_state("ab");
      host_ack();
      host_clr();

      // Simultaneous ack-on-completion and write-on-load
      spi_select(1'b0, 1'b0, '0);
      spi_word($urandom, 8, 1'b0, "sim_pre");
      spi_deselect();
      spi_select(1'b0, 1'b1, 32'h0000_005A);
      check_state("sim_load");
      spi_word(32'h0000_00C3, 8, 1'b1, "sim_w");
      check("sim_rxdata", rxdata, 32'h0000_00C3);
      spi_deselect();
      check_state("sim");
      host_ack();

      // Randomized frames
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 1) == 1) host_write($urandom);
         spi_select(1'($urandom_range(0, 1)), 1'b0, '0);
         nw = $urandom_range(1, 2);
         for (int w = 0; w < nw; w++) begin
            spi_word($urandom, cur_wide ? 32 : 8, 1'b0, "rnd_word");
            if ($urandom_range(0, 2) == 0) host_ack();
         end
         spi_deselect();
         check_state("rnd");
         if ($urandom_range(0, 1) == 1) host_ack();
         if ($urandom_range(0, 3) == 0) host_clr();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
